// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: buffers an input vector, then runs one MAC per cycle per neuron
// against the WEIGHTS image (row-major, word k*N_OUT+j = W[k][j]). Define DENSE_RELU_EN for ReLU output.
module dense_layer_seq #(
    parameter int N_IN      = 784,
    parameter int N_OUT     = 128,
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 64,
    parameter int FRAC_BITS = 0,
    parameter logic [N_IN*N_OUT*DATA_W-1:0] WEIGHTS = '0,
    localparam int IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy
);

    localparam int K_W    = $clog2(N_IN);
    localparam int BIT_AW = $clog2(N_IN * N_OUT * DATA_W);
    localparam logic [K_W-1:0]   K_LAST = K_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_OUT - 1);

    localparam logic signed [ACC_W-1:0]  ACC_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_EMIT} state_t;

    state_t                    state;
    logic [K_W-1:0]            k;
    logic [IDX_W-1:0]          j;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  xbuf [N_IN];

    logic [BIT_AW-1:0]         w_bit;
    logic signed [DATA_W-1:0]  w_cur;
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [DATA_W-1:0]  sat;
    logic signed [DATA_W-1:0]  res;

    // Datapath for the current MAC step; res is only captured on the final step of a neuron.
    always_comb begin
        w_bit    = BIT_AW'((int'(k) * N_OUT + int'(j)) * DATA_W);
        w_cur    = WEIGHTS[w_bit +: DATA_W];
        x_cur    = xbuf[k];
        prod     = w_cur * x_cur;
        acc_next = acc + ACC_W'(prod);
        acc_shr  = acc_next >>> FRAC_BITS;
        if (acc_shr > ACC_MAX)
            sat = DATA_MAX;
        else if (acc_shr < ACC_MIN)
            sat = DATA_MIN;
        else
            sat = acc_shr[DATA_W-1:0];
`ifdef DENSE_RELU_EN
        res = sat[DATA_W-1] ? '0 : sat;
`else
        res = sat;
`endif
    end

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_EMIT);
    assign busy      = (state != S_LOAD) || (k != '0);

    // NOTE: the input buffer has no reset; every element is rewritten in LOAD before MAC reads it.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid)
            xbuf[k] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            k         <= '0;
            j         <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (k == K_LAST) begin
                            k     <= '0;
                            j     <= '0;
                            acc   <= '0;
                            state <= S_MAC;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (k == K_LAST) begin
                        k         <= '0;
                        out_data  <= res;
                        out_index <= j;
                        out_last  <= (j == J_LAST);
                        state     <= S_EMIT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (j == J_LAST) begin
                            j     <= '0;
                            state <= S_LOAD;
                        end else begin
                            j     <= j + 1'b1;
                            k     <= '0;
                            acc   <= '0;
                            state <= S_MAC;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: 4-input, 3-neuron layer with hand-computed results.
// Expected outputs follow DENSE_RELU_EN when the bench is built with it.
module tb_dense_layer_seq;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int DW    = 32;

    // Row-major W[k][j]: k0={1,2,-1}, k1..k3={1,0,-1}; word 0 is the least significant.
    localparam logic [N_IN*N_OUT*DW-1:0] W_IMG = {
        32'hFFFF_FFFF, 32'd0, 32'd1,
        32'hFFFF_FFFF, 32'd0, 32'd1,
        32'hFFFF_FFFF, 32'd0, 32'd1,
        32'hFFFF_FFFF, 32'd2, 32'd1
    };

`ifdef DENSE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    localparam int SAT_MAX = 32'sh7FFF_FFFF;
    localparam int SAT_MIN = 32'sh8000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_index;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_beat_cyc;

    dense_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .ACC_W(64), .FRAC_BITS(0), .WEIGHTS(W_IMG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
        return (RELU && v < 0) ? 0 : v;
    endfunction

    // Presents one word and waits for it to be accepted; in_valid is left high.
    task automatic send_word(input int d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        last_beat_cyc = cyc;
    endtask

    task automatic send_frame(input int x0, input int x1, input int x2, input int x3, input bit hold);
        send_word(x0);
        send_word(x1);
        send_word(x2);
        send_word(x3);
        if (!hold) in_valid = 1'b0;
    endtask

    // Waits for a result, optionally stalls it, and returns it after its handshake edge.
    task automatic get_result(input string tag, input int stall, output logic signed [DW-1:0] d,
                              output logic [1:0] ix, output logic lst, output int hs_cyc);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_in_ready_low"}, in_ready, 0);
        d   = out_data;
        ix  = out_index;
        lst = out_last;
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_data"}, $signed(out_data), d);
                check({tag, "_stall_index"}, out_index, ix);
                check({tag, "_stall_last"}, out_last, lst);
                check({tag, "_stall_in_ready"}, in_ready, 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
        hs_cyc = cyc;
    endtask

    task automatic check_frame(input string tag, input int stall, input int e0, input int e1,
                               input int e2, output int first_hs);
        int exp_y [3];
        int hs [3];
        logic signed [DW-1:0] d;
        logic [1:0] ix;
        logic lst;
        exp_y[0] = e0;
        exp_y[1] = e1;
        exp_y[2] = e2;
        for (int i = 0; i < 3; i++) begin
            get_result($sformatf("%s_r%0d", tag, i), stall, d, ix, lst, hs[i]);
            check($sformatf("%s_y%0d", tag, i), d, exp_y[i]);
            check($sformatf("%s_index%0d", tag, i), ix, i);
            check($sformatf("%s_last%0d", tag, i), lst, (i == 2) ? 1 : 0);
            if (stall == 0 && i > 0)
                check($sformatf("%s_spacing%0d", tag, i), hs[i] - hs[i-1], N_IN + 1);
        end
        check({tag, "_idle"}, out_valid, 0);
        first_hs = hs[0];
    endtask

    initial begin
        int hs0;
        int beat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame, latency and throughput.
        send_frame(1, 2, 3, 4, 1'b0);
        beat = last_beat_cyc;
        check("t1_busy_mac", busy, 1);
        check("t1_in_ready_mac", in_ready, 0);
        check_frame("t1", 0, 10, 2, relu(-10), hs0);
        check("t1_latency", hs0 - beat, N_IN + 1);
        check("t1_back_to_load", in_ready, 1);

        // Stalled results must hold steady.
        out_ready = 1'b0;
        send_frame(3, -1, 2, 5, 1'b0);
        check_frame("t3", 7, 9, 6, relu(-9), hs0);
        out_ready = 1'b1;

        // Saturation in both directions.
        send_frame(SAT_MAX, SAT_MAX, SAT_MAX, SAT_MAX, 1'b0);
        check_frame("t4", 0, SAT_MAX, SAT_MAX, relu(SAT_MIN), hs0);

        // Reset in the middle of loading discards the partial vector.
        send_word(7);
        send_word(9);
        in_valid = 1'b0;
        check("t5_busy_partial", busy, 1);
        rst_n = 1'b0;
        #2;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(1, 2, 3, 4, 1'b0);
        check_frame("t5", 0, 10, 2, relu(-10), hs0);

        // Back-to-back frames with in_valid held high.
        fork
            begin
                send_frame(1, 2, 3, 4, 1'b1);
                send_frame(5, -3, 7, 2, 1'b0);
            end
            begin
                check_frame("t6a", 0, 10, 2, relu(-10), hs0);
                check("t6_in_ready_rise", in_ready, 1);
                check_frame("t6b", 0, 11, 10, relu(-11), hs0);
            end
        join
        check("t6_end_in_ready", in_ready, 1);
        check("t6_end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
